// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar front end: key indices,
// key channel states and default 50 MHz timing constants.
package clock_pkg;

  localparam int KEY_EDIT  = 0;
  localparam int KEY_PLUS  = 1;
  localparam int KEY_MINUS = 2;
  localparam int KEY_SWI   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } key_state_e;

  // 10 ms debounce, 0.5 s first repeat, 10 repeats per second at 50 MHz
  localparam int DEF_DEBOUNCE_CYCLES     = 500000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;
  localparam logic [3:0] DEF_REPEAT_MASK = (4'b0001 << KEY_PLUS) | (4'b0001 << KEY_MINUS);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, debounce filter, press
// pulse generator and optional auto-repeat.
module key_channel
  import clock_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int   REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int   REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter logic REPEAT_EN           = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw_n,
  output logic pulse,
  output logic held,
  output logic repeating,
  output logic held_next
);

  localparam int DCW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RPT_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int RCW     = $clog2(RPT_MAX + 1);
  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST = RCW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RCW-1:0] RATE_LAST  = RCW'(REPEAT_RATE_CYCLES - 1);

  logic            sync1_r, sync2_r;
  logic            stable_r, stable_s;
  logic [DCW-1:0]  cnt_r, cnt_s;
  logic            held_r;
  key_state_e      state_r, state_s;
  logic [RCW-1:0]  rpt_r, rpt_s;
  logic            pulse_r, pulse_s;
  logic            repeating_r;

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    stable_s = stable_r;
    cnt_s    = {DCW{1'b0}};
    if (sync2_r != stable_r) begin
      if (cnt_r == DB_LAST) begin
        stable_s = sync2_r;
      end else begin
        cnt_s = cnt_r + DCW'(1);
      end
    end else begin
      cnt_s = {DCW{1'b0}};
    end
  end

  // Channel FSM driven by the registered debounced level; release always wins
  always_comb begin
    state_s = state_r;
    rpt_s   = rpt_r;
    pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        rpt_s = {RCW{1'b0}};
        if (held_r) begin
          state_s = PRESSED;
          pulse_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      PRESSED: begin
        if (!held_r) begin
          state_s = IDLE;
          rpt_s   = {RCW{1'b0}};
        end else if (!REPEAT_EN) begin
          rpt_s = {RCW{1'b0}};
        end else if (rpt_r == DELAY_LAST) begin
          state_s = REPEAT;
          pulse_s = 1'b1;
          rpt_s   = {RCW{1'b0}};
        end else begin
          rpt_s = rpt_r + RCW'(1);
        end
      end
      REPEAT: begin
        if (!held_r) begin
          state_s = IDLE;
          rpt_s   = {RCW{1'b0}};
        end else if (rpt_r == RATE_LAST) begin
          pulse_s = 1'b1;
          rpt_s   = {RCW{1'b0}};
        end else begin
          rpt_s = rpt_r + RCW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        rpt_s   = {RCW{1'b0}};
      end
    endcase
  end

  // State and output registers; the repeating flag drops with the debounced release
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r     <= 1'b1;
      sync2_r     <= 1'b1;
      stable_r    <= 1'b1;
      cnt_r       <= {DCW{1'b0}};
      held_r      <= 1'b0;
      state_r     <= IDLE;
      rpt_r       <= {RCW{1'b0}};
      pulse_r     <= 1'b0;
      repeating_r <= 1'b0;
    end else begin
      sync1_r     <= key_raw_n;
      sync2_r     <= sync1_r;
      stable_r    <= stable_s;
      cnt_r       <= cnt_s;
      held_r      <= ~stable_r;
      state_r     <= state_s;
      rpt_r       <= rpt_s;
      pulse_r     <= pulse_s;
      repeating_r <= (state_s == REPEAT) & ~stable_r;
    end
  end

  assign pulse     = pulse_r;
  assign held      = held_r;
  assign repeating = repeating_r;
  assign held_next = ~stable_r;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw Edit/Plus/Minus/Swi buttons into press strobes,
// debounced held levels and auto-repeat status.
module key_conditioner
  import clock_pkg::*;
#(
  parameter int                  NUM_KEYS            = 4,
  parameter int                  DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int                  REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int                  REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK         = DEF_REPEAT_MASK
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw_n,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_held,
  output logic [NUM_KEYS-1:0] key_repeating,
  output logic                key_any
);

  logic [NUM_KEYS-1:0] held_next_s;
  logic                key_any_r;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .REPEAT_EN          (REPEAT_MASK[i])
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .key_raw_n(key_raw_n[i]),
      .pulse    (key_pulse[i]),
      .held     (key_held[i]),
      .repeating(key_repeating[i]),
      .held_next(held_next_s[i])
    );
  end

  // key_any registered from the same next-held levels so it aligns with key_held
  always_ff @(posedge clk) begin
    if (reset) begin
      key_any_r <= 1'b0;
    end else begin
      key_any_r <= |held_next_s;
    end
  end

  assign key_any = key_any_r;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: expected press/repeat pulses are queued
// with their absolute cycle; a monitor matches them against key_pulse.
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw_n;
  logic [3:0] key_pulse, key_held, key_repeating;
  logic       key_any;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
  } exp_t;
  exp_t q[$];

  key_conditioner #(
    .NUM_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES(5), .REPEAT_MASK(4'b0110)
  ) dut (
    .clk(clk), .reset(reset), .key_raw_n(key_raw_n), .key_pulse(key_pulse),
    .key_held(key_held), .key_repeating(key_repeating), .key_any(key_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every observed pulse must match the head of the queue
  always @(negedge clk) begin : mon
    exp_t e;
    if (key_pulse !== 4'b0000) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pulse_unexpected: got %b at cycle %0d, required none", key_pulse, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.mask !== key_pulse) begin
          fails++;
          $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                   key_pulse, cyc, e.mask, e.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      tests++;
      fails++;
      e = q.pop_front();
      $display("FAIL pulse_missing: got none, required %b at cycle %0d", e.mask, e.cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [3:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, m, r;
    reset     = 1'b1;
    key_raw_n = 4'hF;

    // Reset, then idle
    wait_until(2);
    check("reset_outputs", {key_pulse, key_held, key_repeating, key_any}, 32'h0);
    wait_until(3);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("idle_outputs", {key_pulse, key_held, key_repeating, key_any}, 32'h0);
    end

    // Edit: single press, no repeat
    n = cyc;
    key_raw_n[0] = 1'b0;
    push(n + 8, 4'b0001);
    wait_until(n + 6);
    check("edit_held_before", key_held, 32'h0);
    wait_until(n + 7);
    check("edit_held", key_held, 32'h1);
    check("edit_any", key_any, 32'h1);
    wait_until(n + 50);
    key_raw_n[0] = 1'b1;
    m = cyc;
    wait_until(m + 6);
    check("edit_held_late", key_held, 32'h1);
    wait_until(m + 7);
    check("edit_released", key_held, 32'h0);
    check("edit_any_released", key_any, 32'h0);
    wait_until(m + 15);

    // Plus: bounce shorter than the debounce window
    n = cyc;
    key_raw_n[1] = 1'b0;
    wait_until(n + 3);
    key_raw_n[1] = 1'b1;
    wait_until(n + 4);
    key_raw_n[1] = 1'b0;
    wait_until(n + 7);
    key_raw_n[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("bounce_held", key_held, 32'h0);
      check("bounce_pulse", key_pulse, 32'h0);
    end

    // Plus: hold 60 cycles with auto-repeat
    n = cyc;
    key_raw_n[1] = 1'b0;
    push(n + 8, 4'b0010);
    push(n + 28, 4'b0010);
    push(n + 33, 4'b0010);
    push(n + 38, 4'b0010);
    push(n + 43, 4'b0010);
    push(n + 48, 4'b0010);
    push(n + 53, 4'b0010);
    push(n + 58, 4'b0010);
    push(n + 63, 4'b0010);
    wait_until(n + 27);
    check("plus_rep_before", key_repeating, 32'h0);
    wait_until(n + 28);
    check("plus_rep", key_repeating, 32'h2);
    wait_until(n + 60);
    key_raw_n[1] = 1'b1;
    m = cyc;
    wait_until(m + 6);
    check("plus_rep_late", key_repeating, 32'h2);
    wait_until(m + 7);
    check("plus_rep_released", key_repeating, 32'h0);
    check("plus_held_released", key_held, 32'h0);
    wait_until(m + 15);

    // Minus + Swi together; Swi held long without repeat
    n = cyc;
    key_raw_n = 4'b0011;
    push(n + 8, 4'b1100);
    wait_until(n + 6);
    check("dual_any_before", key_any, 32'h0);
    wait_until(n + 7);
    check("dual_held", key_held, 32'hC);
    check("dual_any", key_any, 32'h1);
    wait_until(n + 10);
    key_raw_n[2] = 1'b1;
    wait_until(n + 20);
    check("swi_only_held", key_held, 32'h8);
    check("swi_only_any", key_any, 32'h1);
    wait_until(n + 40);
    check("swi_no_repeat", key_repeating, 32'h0);
    wait_until(n + 60);
    key_raw_n[3] = 1'b1;
    m = cyc;
    wait_until(m + 6);
    check("swi_any_late", key_any, 32'h1);
    wait_until(m + 7);
    check("swi_any_released", key_any, 32'h0);
    wait_until(m + 15);

    // Reset while Plus repeats, key kept held through reset
    n = cyc;
    key_raw_n[1] = 1'b0;
    push(n + 8, 4'b0010);
    push(n + 28, 4'b0010);
    push(n + 33, 4'b0010);
    wait_until(n + 35);
    reset = 1'b1;
    for (int i = 36; i <= 38; i++) begin
      wait_until(n + i);
      check("midreset_outputs", {key_pulse, key_held, key_repeating, key_any}, 32'h0);
    end
    reset = 1'b0;
    r = cyc;
    push(r + 8, 4'b0010);
    push(r + 28, 4'b0010);
    push(r + 33, 4'b0010);
    wait_until(r + 1);
    check("post_reset_outputs", {key_pulse, key_held, key_repeating, key_any}, 32'h0);
    wait_until(r + 27);
    check("restart_rep_before", key_repeating, 32'h0);
    wait_until(r + 28);
    check("restart_rep", key_repeating, 32'h2);
    wait_until(r + 30);
    key_raw_n[1] = 1'b1;
    wait_until(r + 45);
    check("final_outputs", {key_pulse, key_held, key_repeating, key_any}, 32'h0);

    wait_until(cyc + 20);
    check("pulse_queue_empty", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Conditions the four raw push-button inputs (Edit, Plus, Minus, Swi) before the clock/calendar top-level manager consumes them.
- Per key, in order: 2-flop synchroniser, debounce filter, single-cycle press pulse generator.
- Plus/Minus auto-repeat while held, so the user can step fast through values in edit mode.
- Outputs are active-high one-clock strobes plus debounced held levels.

Parameters:
- NUM_KEYS, 4, number of key channels; index 0=Edit, 1=Plus, 2=Minus, 3=Swi.
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a level change (min 1).
- REPEAT_DELAY_CYCLES, 25000000, cycles from the initial press pulse to the first repeat pulse (min 1).
- REPEAT_RATE_CYCLES, 5000000, cycles between successive repeat pulses (min 1).
- REPEAT_MASK, 4'b0110, bit i=1 enables auto-repeat on key i.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- key_raw_n, input, NUM_KEYS, raw asynchronous buttons, active-low (0=pressed).
- key_pulse, output, NUM_KEYS, one-cycle strobe per accepted press or repeat.
- key_held, output, NUM_KEYS, debounced level, 1=pressed.
- key_repeating, output, NUM_KEYS, 1 while the channel is in the REPEAT state.
- key_any, output, 1, OR of key_held.

Behaviour:
- Reset, synchronous, active-high; clock clk.
- On reset, every channel goes to:
  - synchroniser flops 1 (released);
  - stable level released;
  - counters 0;
  - FSM IDLE.
- All outputs are 0 during and on the first cycle after reset.
- Synchroniser: two flops per key. Downstream logic sees only the second flop (sync).
- Debounce:
  - cnt increments each cycle sync != stable; cnt clears to 0 whenever sync == stable.
  - On the edge where cnt == DEBOUNCE_CYCLES-1 and sync != stable: stable flips and cnt clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored completely.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- key_held = ~stable, registered.
- Press latency: raw goes low and stays low → key_pulse high for exactly one cycle, DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the low level.
- Release never produces a pulse.
- Channel FSM (rpt counter width sized for max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)):
  - IDLE: on debounced press → PRESSED; emit pulse; rpt=0.
  - PRESSED: rpt increments each cycle.
    - If REPEAT_MASK[i] and rpt == REPEAT_DELAY_CYCLES-1 → REPEAT; emit pulse; rpt=0.
    - Keys without repeat stay in PRESSED until release.
  - REPEAT: rpt increments; at rpt == REPEAT_RATE_CYCLES-1 emit pulse and rpt=0.
  - Any state: debounced release → IDLE next edge, rpt=0, no pulse. A repeat due on the same edge as the release is suppressed (release wins).
- key_repeating = (state == REPEAT).
- Channels are fully independent. Simultaneous presses on several keys give simultaneous pulses; no priority or masking here.
- Reset mid-press cancels everything. A key still held when reset deasserts is treated as a fresh press: it pulses DEBOUNCE_CYCLES+3 edges after the first post-reset edge.
- Counters saturate only by design (cleared at their thresholds); no wrap-around is reachable.
- key_pulse is registered; no combinational path from key_raw_n to any output.

Decomposition:
- Shared package clock_pkg:
  - key index constants KEY_EDIT=0, KEY_PLUS=1, KEY_MINUS=2, KEY_SWI=3;
  - channel state enum {IDLE, PRESSED, REPEAT};
  - default timing constants for 50 MHz.
- One sub-module, key_channel, holds synchroniser, debounce, FSM and repeat counter for one key. Parameters: DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES, REPEAT_EN.
- key_conditioner generate-instantiates NUM_KEYS key_channels and forms key_any.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=5):
- Hold reset 3 cycles with all keys released, then release reset → all outputs 0 for 10 idle cycles.
- key_raw_n[0] low for 50 cycles, then high:
  - key_pulse[0] high exactly 1 cycle, 7 edges after the low sample; no further pulses;
  - key_held[0] high from edge 6 until 6 edges after release.
- key_raw_n[1] low for 3 cycles, high for 1, low for 3 (bounce) → no pulse, key_held[1] stays 0.
- key_raw_n[1] held 60 cycles:
  - pulses at press+7, then +20 (key_repeating[1] rises), then every 5 cycles;
  - after release, no pulses and key_repeating[1]=0 within 6 edges.
- key_raw_n[2] and key_raw_n[3] pressed on the same cycle:
  - both pulse on the same cycle;
  - key_raw_n[3] held 60 cycles gives no repeat (mask bit 0);
  - key_any=1 while either is held.
- Assert reset while key 1 is in REPEAT, keep the key held, deassert reset → all outputs 0 during reset; fresh single pulse 7 edges after deassert; first repeat 20 cycles after that pulse.
